// File: rtl/seg14_scan_ctrl_if.sv
// ============================================================================
// Module   : seg14_scan_ctrl_if
// Brief    : Message-write, control and display-pin bundle for seg14_scan_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seg14_scan_ctrl_if #(
  parameter int SEG_W     = 14,
  parameter int DIGITS    = 12,
  parameter int MSG_DEPTH = 32
) ();
  logic                           i_en;
  logic                           i_wr_en;
  logic [$clog2(MSG_DEPTH)-1:0]   i_wr_addr;
  logic [SEG_W-1:0]               i_wr_data;
  logic [$clog2(MSG_DEPTH):0]     i_msg_len;
  logic                           i_scroll_en;
  logic [DIGITS-1:0]              o_sel;
  logic [SEG_W-1:0]               o_segm;
  logic                           o_frame_done;

  modport master (
    output i_en, i_wr_en, i_wr_addr, i_wr_data, i_msg_len, i_scroll_en,
    input  o_sel, o_segm, o_frame_done
  );

  modport slave (
    input  i_en, i_wr_en, i_wr_addr, i_wr_data, i_msg_len, i_scroll_en,
    output o_sel, o_segm, o_frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seg14_scan_ctrl.sv
// ============================================================================
// Module   : seg14_scan_ctrl
// Brief    : Multiplexed 14-segment scan scheduler with blanking and scrolling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg14_scan_ctrl #(
  parameter int DIGITS        = 12,
  parameter int SEG_W         = 14,
  parameter int MSG_DEPTH     = 32,
  parameter int DWELL_CYC     = 1000,
  parameter int BLANK_CYC     = 8,
  parameter int SCROLL_FRAMES = 50
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  seg14_scan_ctrl_if.slave bus
);

  localparam int c_AW   = $clog2(MSG_DEPTH);
  localparam int c_LW   = c_AW + 1;
  localparam int c_DGW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_CMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int c_CW   = $clog2(c_CMAX + 1);
  localparam int c_FW   = $clog2(SCROLL_FRAMES + 1);

  localparam logic [c_CW-1:0]   c_BLANK_LAST = c_CW'(BLANK_CYC - 1);
  localparam logic [c_CW-1:0]   c_DWELL_LAST = c_CW'(DWELL_CYC - 1);
  localparam logic [c_DGW-1:0]  c_LAST_DIGIT = c_DGW'(DIGITS - 1);
  localparam logic [c_FW-1:0]   c_FC_LAST    = c_FW'(SCROLL_FRAMES - 1);
  localparam logic [DIGITS-1:0] c_ONE_SEL    = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_DGW-1:0]  r_digit;
  logic [c_AW-1:0]   r_offset;
  logic [c_AW-1:0]   r_idx;
  logic [c_FW-1:0]   r_fc;
  logic [c_LW-1:0]   r_len;
  logic [DIGITS-1:0] r_sel;
  logic [SEG_W-1:0]  r_segm;
  logic              r_frame_done;
  logic [SEG_W-1:0]  r_buf [MSG_DEPTH];

  logic              w_start;
  logic              w_enter_drive;
  logic              w_next_digit;
  logic              w_frame_end;
  logic [SEG_W-1:0]  w_pattern;
  logic [c_AW-1:0]   w_idx_inc;
  logic [c_AW-1:0]   w_off_nxt;
  logic [c_AW-1:0]   w_start_off;
  logic [c_FW-1:0]   w_fc_nxt;

  always_ff @(posedge clk) begin
    if (bus.i_wr_en) begin
      r_buf[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_enter_drive = 1'b0;
    w_next_digit  = 1'b0;
    w_frame_end   = 1'b0;
    if (!bus.i_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_start     = 1'b1;
        end
        S_BLANK: begin
          if (r_cnt == c_BLANK_LAST) begin
            w_state_nxt   = S_DRIVE;
            w_enter_drive = 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == c_DWELL_LAST) begin
            w_state_nxt  = S_BLANK;
            w_next_digit = 1'b1;
            w_frame_end  = (r_digit == c_LAST_DIGIT);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // r_idx tracks (offset + digit) mod len incrementally, so no divider is needed.
  always_comb begin
    w_pattern = '0;
    if (r_len == '0) begin
      w_pattern = '0;
    end else if (bus.i_scroll_en) begin
      w_pattern = r_buf[r_idx];
    end else if (c_LW'(r_digit) < r_len) begin
      w_pattern = r_buf[c_AW'(r_digit)];
    end

    w_idx_inc = ((c_LW'(r_idx) + c_LW'(1)) == r_len) ? '0 : r_idx + c_AW'(1);

    w_fc_nxt  = r_fc;
    w_off_nxt = r_offset;
    if (!bus.i_scroll_en) begin
      w_off_nxt = '0;
      w_fc_nxt  = '0;
    end else if (r_fc == c_FC_LAST) begin
      w_fc_nxt = '0;
      if ((r_len == '0) || ((c_LW'(r_offset) + c_LW'(1)) == r_len)) begin
        w_off_nxt = '0;
      end else begin
        w_off_nxt = r_offset + c_AW'(1);
      end
    end else begin
      w_fc_nxt = r_fc + c_FW'(1);
    end
    if (bus.i_msg_len <= c_LW'(w_off_nxt)) begin
      w_off_nxt = '0;
    end

    w_start_off = (bus.i_msg_len <= c_LW'(r_offset)) ? '0 : r_offset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_digit      <= '0;
      r_offset     <= '0;
      r_idx        <= '0;
      r_fc         <= '0;
      r_len        <= '0;
      r_sel        <= '0;
      r_segm       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (!bus.i_en) begin
        r_cnt   <= '0;
        r_digit <= '0;
        r_sel   <= '0;
        r_segm  <= '0;
      end else if (w_start) begin
        r_cnt    <= '0;
        r_digit  <= '0;
        r_len    <= bus.i_msg_len;
        r_offset <= w_start_off;
        r_idx    <= w_start_off;
      end else if (w_enter_drive) begin
        r_cnt  <= '0;
        r_sel  <= c_ONE_SEL << r_digit;
        r_segm <= w_pattern;
      end else if (w_next_digit) begin
        r_cnt  <= '0;
        r_sel  <= '0;
        r_segm <= '0;
        if (w_frame_end) begin
          r_digit  <= '0;
          r_len    <= bus.i_msg_len;
          r_offset <= w_off_nxt;
          r_idx    <= w_off_nxt;
          r_fc     <= w_fc_nxt;
        end else begin
          r_digit <= r_digit + c_DGW'(1);
          r_idx   <= w_idx_inc;
        end
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

  assign bus.o_sel        = r_sel;
  assign bus.o_segm       = r_segm;
  assign bus.o_frame_done = r_frame_done;

endmodule

`default_nettype wire
